// File: rtl/ifu.sv
// Instruction fetch unit: owns the PC, issues single-beat AR/R reads to instruction
// memory and hands each fetched word with its PC to decode; applies jump redirects.
module ifu #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        jump_flag,
  input  logic [31:0] jump_target,
  output logic [31:0] imem_araddr,
  output logic        imem_arvalid,
  input  logic        imem_arready,
  input  logic [31:0] imem_rdata,
  input  logic [1:0]  imem_rresp,
  input  logic        imem_rvalid,
  output logic        imem_rready,
  output logic [31:0] inst_if,
  output logic [31:0] pc_if,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic        fetch_err
);

  // state | meaning
  // IDLE  | one cycle after reset, loads the first fetch address
  // AR    | read address presented, waiting for arready
  // R     | read outstanding, waiting for rvalid
  // OUT   | instruction presented to decode, waiting for inst_ready or a redirect
  typedef enum logic [1:0] {IDLE, AR, R, OUT} state_t;

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic [31:0] redir_tgt, redir_tgt_nxt;
  logic        redir_pend, redir_pend_nxt;
  logic [31:0] araddr_nxt, inst_nxt, pc_if_nxt, redir_pc;
  logic        arvalid_nxt, rready_nxt, valid_nxt, err_nxt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      pc           <= RESET_PC;
      redir_tgt    <= 32'h0;
      redir_pend   <= 1'b0;
      imem_araddr  <= RESET_PC;
      imem_arvalid <= 1'b0;
      imem_rready  <= 1'b0;
      inst_if      <= 32'h0;
      pc_if        <= RESET_PC;
      inst_valid   <= 1'b0;
      fetch_err    <= 1'b0;
    end else begin
      state        <= state_nxt;
      pc           <= pc_nxt;
      redir_tgt    <= redir_tgt_nxt;
      redir_pend   <= redir_pend_nxt;
      imem_araddr  <= araddr_nxt;
      imem_arvalid <= arvalid_nxt;
      imem_rready  <= rready_nxt;
      inst_if      <= inst_nxt;
      pc_if        <= pc_if_nxt;
      inst_valid   <= valid_nxt;
      fetch_err    <= err_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    pc_nxt         = pc;
    redir_tgt_nxt  = redir_tgt;
    redir_pend_nxt = redir_pend;
    araddr_nxt     = imem_araddr;
    arvalid_nxt    = imem_arvalid;
    rready_nxt     = imem_rready;
    inst_nxt       = inst_if;
    pc_if_nxt      = pc_if;
    valid_nxt      = inst_valid;
    err_nxt        = fetch_err;
    redir_pc       = jump_flag ? jump_target : redir_tgt;

    case (state)
      IDLE: begin
        state_nxt   = AR;
        arvalid_nxt = 1'b1;
        araddr_nxt  = jump_flag ? jump_target : pc;
        if (jump_flag) pc_nxt = jump_target;
      end

      AR: begin
        // the address is already committed, so a redirect only gets remembered
        if (jump_flag) begin
          redir_pend_nxt = 1'b1;
          redir_tgt_nxt  = jump_target;
        end
        if (imem_arvalid && imem_arready) begin
          arvalid_nxt = 1'b0;
          rready_nxt  = 1'b1;
          state_nxt   = R;
        end
      end

      R: begin
        if (imem_rvalid && imem_rready) begin
          rready_nxt = 1'b0;
          if (!redir_pend && !jump_flag) begin
            state_nxt = OUT;
            valid_nxt = 1'b1;
            pc_if_nxt = pc;
            inst_nxt  = (imem_rresp == 2'b00) ? imem_rdata : 32'h0;
            err_nxt   = (imem_rresp != 2'b00);
          end else begin
            // stale response: drop it and refetch from the newest target
            pc_nxt         = redir_pc;
            araddr_nxt     = redir_pc;
            arvalid_nxt    = 1'b1;
            redir_pend_nxt = 1'b0;
            state_nxt      = AR;
          end
        end else if (jump_flag) begin
          redir_pend_nxt = 1'b1;
          redir_tgt_nxt  = jump_target;
        end
      end

      OUT: begin
        if (jump_flag) begin
          pc_nxt      = jump_target;
          araddr_nxt  = jump_target;
          arvalid_nxt = 1'b1;
          valid_nxt   = 1'b0;
          err_nxt     = 1'b0;
          state_nxt   = AR;
        end else if (inst_valid && inst_ready) begin
          pc_nxt      = pc + 32'd4;
          araddr_nxt  = pc + 32'd4;
          arvalid_nxt = 1'b1;
          valid_nxt   = 1'b0;
          err_nxt     = 1'b0;
          state_nxt   = AR;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ifu.sv
// Bench for ifu: directed timing sequence followed by randomized memory latency,
// backpressure, redirects and resets, checked by a scoreboard of expected fetches.
module tb_ifu;
  localparam logic [31:0] RESET_PC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        jump_flag, inst_ready;
  logic [31:0] jump_target;
  logic [31:0] imem_araddr, imem_rdata, inst_if, pc_if;
  logic        imem_arvalid, imem_arready, imem_rvalid, imem_rready;
  logic [1:0]  imem_rresp;
  logic        inst_valid, fetch_err;

  ifu #(.RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst_n(rst_n), .jump_flag(jump_flag), .jump_target(jump_target),
    .imem_araddr(imem_araddr), .imem_arvalid(imem_arvalid), .imem_arready(imem_arready),
    .imem_rdata(imem_rdata), .imem_rresp(imem_rresp), .imem_rvalid(imem_rvalid),
    .imem_rready(imem_rready), .inst_if(inst_if), .pc_if(pc_if), .inst_valid(inst_valid),
    .inst_ready(inst_ready), .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        err;
  } exp_t;

  int n_chk = 0;
  int n_err = 0;
  int ar_pct = 100, dly_lo = 0, dly_hi = 0, ar_low = 0;

  // memory contents and error map depend only on the address
  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return (a == RESET_PC) ? 32'h0000_0413 : ((a * 32'h9E37_79B1) ^ 32'h0000_0013);
  endfunction

  function automatic logic mem_err(input logic [31:0] a);
    return (a[6:2] == 5'h0B);
  endfunction

  function automatic exp_t mk(input logic [31:0] a);
    exp_t e;
    e.pc   = a;
    e.err  = mem_err(a);
    e.inst = e.err ? 32'h0 : mem_data(a);
    return e;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // memory responder
  initial begin : mem
    logic ar_hs, r_hs, rst_seen;
    logic [31:0] a_s, m_addr;
    int m_dly;
    logic busy;
    busy = 1'b0; m_dly = 0; m_addr = 32'h0;
    imem_arready = 1'b1; imem_rvalid = 1'b0; imem_rdata = 32'h0; imem_rresp = 2'b00;
    forever begin
      @(negedge clk);
      ar_hs = imem_arvalid && imem_arready;
      r_hs = imem_rvalid && imem_rready;
      rst_seen = !rst_n;
      a_s = imem_araddr;
      @(posedge clk);
      #1;
      if (rst_seen) begin
        busy = 1'b0;
        imem_rvalid = 1'b0;
      end else begin
        if (r_hs) begin
          busy = 1'b0;
          imem_rvalid = 1'b0;
        end
        if (ar_hs) begin
          busy = 1'b1;
          m_addr = a_s;
          m_dly = int'($urandom_range(dly_hi, dly_lo));
        end
      end
      if (busy && !imem_rvalid) begin
        if (m_dly == 0) begin
          imem_rvalid = 1'b1;
          imem_rdata = mem_data(m_addr);
          imem_rresp = mem_err(m_addr) ? 2'b10 : 2'b00;
        end else m_dly--;
      end
      if (!imem_rvalid) begin
        imem_rdata = $urandom;
        imem_rresp = 2'($urandom);
      end
      if (ar_low > 0) begin
        imem_arready = 1'b0;
        ar_low--;
      end else imem_arready = (int'($urandom_range(99, 0)) < ar_pct);
    end
  end

  // monitor + reference model: the next presented fetch is always the latest jump
  // target, or the successor of the last accepted instruction, or RESET_PC after reset
  exp_t q[$];
  exp_t cur;
  logic rst_q = 1'b0;
  logic prev_valid = 1'b0;
  int idle = 0;

  always @(negedge clk) begin
    if (!rst_q) begin
      chk("rst_arvalid", {31'h0, imem_arvalid}, 32'h0);
      chk("rst_rready", {31'h0, imem_rready}, 32'h0);
      chk("rst_inst_valid", {31'h0, inst_valid}, 32'h0);
      chk("rst_fetch_err", {31'h0, fetch_err}, 32'h0);
      chk("rst_inst_if", inst_if, 32'h0);
      chk("rst_pc_if", pc_if, RESET_PC);
      chk("rst_araddr", imem_araddr, RESET_PC);
      prev_valid = 1'b0;
      idle = 0;
    end else begin
      chk("ar_r_exclusive", {31'h0, imem_arvalid & imem_rready}, 32'h0);
      if (inst_valid) begin
        idle = 0;
        if (!prev_valid) begin
          if (q.size() == 0) begin
            n_chk++;
            n_err++;
            $display("FAIL unexpected_inst: got pc %h expected no instruction at %0t", pc_if, $time);
          end else cur = q.pop_front();
        end
        chk("pc_if", pc_if, cur.pc);
        chk("inst_if", inst_if, cur.inst);
        chk("fetch_err", {31'h0, fetch_err}, {31'h0, cur.err});
      end else begin
        chk("err_without_valid", {31'h0, fetch_err}, 32'h0);
        idle++;
        if (idle == 200) begin
          n_chk++;
          n_err++;
          $display("FAIL fetch_timeout: got no instruction for %0d cycles, required fewer", idle);
        end
      end
      prev_valid = inst_valid;
    end
    if (!rst_n) begin
      q.delete();
      q.push_back(mk(RESET_PC));
    end else if (jump_flag) begin
      q.delete();
      q.push_back(mk(jump_target));
    end else if (rst_q && inst_valid && inst_ready) begin
      q.delete();
      q.push_back(mk(cur.pc + 32'd4));
    end
    rst_q = rst_n;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic samp();
    @(negedge clk);
  endtask

  initial begin
    inst_ready = 1'b0; jump_flag = 1'b0; jump_target = 32'h0;
    repeat (3) step();
    rst_n = 1'b1;                                    // R0
    samp(); chk("idle_no_arvalid", {31'h0, imem_arvalid}, 32'h0);
    step(); samp();                                  // R0+1
    chk("first_arvalid", {31'h0, imem_arvalid}, 32'h1);
    chk("first_araddr", imem_araddr, RESET_PC);
    step(); samp();                                  // R0+2
    chk("first_rready", {31'h0, imem_rready}, 32'h1);
    step(); samp();                                  // R0+3
    chk("first_valid", {31'h0, inst_valid}, 32'h1);
    chk("first_inst", inst_if, 32'h0000_0413);
    step(); step();                                  // R0+4, R0+5 decode stall
    step(); inst_ready = 1'b1; samp();               // R0+6
    chk("stall_valid_held", {31'h0, inst_valid}, 32'h1);
    ar_low = 2;
    step(); inst_ready = 1'b0; samp();               // R0+7
    chk("next_arvalid", {31'h0, imem_arvalid}, 32'h1);
    chk("next_araddr", imem_araddr, RESET_PC + 32'd4);
    chk("valid_dropped", {31'h0, inst_valid}, 32'h0);
    step(); samp();                                  // R0+8 arready low
    chk("ar_hold_araddr", imem_araddr, RESET_PC + 32'd4);
    step(); samp();                                  // R0+9 handshake
    chk("ar_hold_arvalid", {31'h0, imem_arvalid}, 32'h1);
    step(); samp();                                  // R0+10
    chk("r_after_stall", {31'h0, imem_rready}, 32'h1);
    step(); inst_ready = 1'b1; samp();               // R0+11
    chk("second_valid", {31'h0, inst_valid}, 32'h1);
    chk("second_pc", pc_if, RESET_PC + 32'd4);
    step(); samp();                                  // R0+12
    chk("third_araddr", imem_araddr, RESET_PC + 32'd8);
    step(); samp();                                  // R0+13
    step(); jump_flag = 1'b1; jump_target = 32'h8000_0100; samp();  // R0+14
    chk("third_pc", pc_if, RESET_PC + 32'd8);
    step(); jump_flag = 1'b0; samp();                // R0+15
    chk("redir_out_valid", {31'h0, inst_valid}, 32'h0);
    chk("redir_out_arvalid", {31'h0, imem_arvalid}, 32'h1);
    chk("redir_out_araddr", imem_araddr, 32'h8000_0100);
    step(); samp(); dly_lo = 4; dly_hi = 4;          // R0+16
    step(); samp();                                  // R0+17
    chk("redir_pc", pc_if, 32'h8000_0100);
    step(); inst_ready = 1'b0; samp();               // R0+18
    chk("inflight_araddr", imem_araddr, 32'h8000_0104);
    step(); samp(); dly_lo = 0; dly_hi = 0;          // R0+19
    chk("inflight_valid0", {31'h0, inst_valid}, 32'h0);
    step(); jump_flag = 1'b1; jump_target = 32'h8000_0200; samp();  // R0+20
    chk("inflight_valid1", {31'h0, inst_valid}, 32'h0);
    step(); jump_flag = 1'b0; samp();                // R0+21
    chk("inflight_valid2", {31'h0, inst_valid}, 32'h0);
    step(); jump_flag = 1'b1; jump_target = 32'h8000_0300; samp();  // R0+22
    chk("inflight_rready", {31'h0, imem_rready}, 32'h1);
    step(); jump_flag = 1'b0; samp();                // R0+23 response arrives
    chk("inflight_valid3", {31'h0, inst_valid}, 32'h0);
    step(); samp(); dly_lo = 3; dly_hi = 3;          // R0+24
    chk("inflight_discard", {31'h0, inst_valid}, 32'h0);
    chk("inflight_refetch", {31'h0, imem_arvalid}, 32'h1);
    chk("inflight_latest", imem_araddr, 32'h8000_0300);
    step(); jump_flag = 1'b1; jump_target = 32'h8000_0400; samp();  // R0+25
    step(); jump_flag = 1'b0; rst_n = 1'b0; samp(); dly_lo = 0; dly_hi = 0;  // R0+26
    step(); rst_n = 1'b1; samp();                    // R0+27 reset values
    chk("midrst_arvalid", {31'h0, imem_arvalid}, 32'h0);
    step(); samp();                                  // R0+28
    chk("restart_araddr", imem_araddr, RESET_PC);
    chk("restart_arvalid", {31'h0, imem_arvalid}, 32'h1);
    step(); samp();                                  // R0+29
    step(); inst_ready = 1'b1; jump_flag = 1'b1; jump_target = 32'h8000_002C; samp();  // R0+30
    chk("restart_pc", pc_if, RESET_PC);
    step(); jump_flag = 1'b0; samp();                // R0+31
    chk("err_araddr", imem_araddr, 32'h8000_002C);
    step(); samp();                                  // R0+32
    step(); samp();                                  // R0+33
    chk("err_valid", {31'h0, inst_valid}, 32'h1);
    chk("err_inst", inst_if, 32'h0);
    chk("err_flag", {31'h0, fetch_err}, 32'h1);
    step(); samp();                                  // R0+34
    chk("err_cleared", {31'h0, fetch_err}, 32'h0);
    chk("err_next_araddr", imem_araddr, 32'h8000_0030);

    ar_pct = 70; dly_lo = 0; dly_hi = 3;
    for (int i = 0; i < 4000; i++) begin
      step();
      rst_n = (int'($urandom_range(999, 0)) != 0);
      inst_ready = (int'($urandom_range(99, 0)) < 60);
      jump_flag = (int'($urandom_range(99, 0)) < 6);
      jump_target = 32'h8000_0000 | {24'h0, 8'($urandom)};
    end
    step(); rst_n = 1'b1; jump_flag = 1'b0; inst_ready = 1'b1;
    repeat (10) step();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/ifu.md
# ifu

Instruction fetch unit for the multicycle NPC core. It owns the architectural PC and issues single-beat reads to instruction memory over an AXI4-Lite-style AR/R channel. It presents each fetched word with its PC to the decode stage over a valid/ready handshake and applies jump redirects coming back from the jump logic. It is the producer side of the decode-stage `inst`/`pc` interface.

## Interface

- `RESET_PC`, default `32'h8000_0000`: PC of the first fetch after reset.

- `clk` in 1: the single clock.
- `rst_n` in 1: reset, synchronous and active-low, sampled on the `clk` rising edge.
- `jump_flag` in 1: single-cycle redirect request.
- `jump_target` in 32: redirect PC, valid when `jump_flag`=1.
- `imem_araddr` out 32: read address.
- `imem_arvalid` out 1: read address valid.
- `imem_arready` in 1: read address accepted.
- `imem_rdata` in 32: read data.
- `imem_rresp` in 2: read response; 2'b00 = OKAY.
- `imem_rvalid` in 1: read data valid.
- `imem_rready` out 1: fetch unit accepts read data.
- `inst_if` out 32: instruction to decode.
- `pc_if` out 32: PC of `inst_if`.
- `inst_valid` out 1: `inst_if`/`pc_if` valid.
- `inst_ready` in 1: decode accepts the instruction.
- `fetch_err` out 1: the presented instruction came from a non-OKAY response.

## Operation

- All outputs are registered. FSM states: IDLE, AR, R, OUT.
- **Reset** (`rst_n`=0 at an edge) forces the following, regardless of the current state, including mid-transaction:
  - state=IDLE; pc=`RESET_PC`.
  - `imem_arvalid`=0, `imem_rready`=0, `inst_valid`=0, `fetch_err`=0.
  - `inst_if`=0, `pc_if`=`RESET_PC`, `imem_araddr`=`RESET_PC`.
  - redirect-pending flag cleared.
- **IDLE → AR** unconditionally on the next edge. `imem_araddr`=pc and `imem_arvalid`=1.
- **AR:** hold `imem_arvalid` and `imem_araddr` stable until `imem_arvalid & imem_arready`. Then go to R with `imem_rready`=1 and `imem_arvalid`=0.
- **R:** on `imem_rvalid & imem_rready`, latch the response.
  - If no redirect is pending and `jump_flag`=0 this cycle:
    - go to OUT;
    - `inst_valid`=1, `pc_if`=pc;
    - `inst_if`=`imem_rdata` if `imem_rresp`==0, else `inst_if`=0 and `fetch_err`=1.
  - Otherwise discard the data, set pc=redirect target, clear the pending flag and go to AR.
- **OUT:** hold `inst_if`, `pc_if`, `inst_valid` and `fetch_err` stable while `inst_ready`=0.
  - On `inst_valid & inst_ready` with `jump_flag`=0: pc=pc+4 (wraps mod 2^32), go to AR, drop `inst_valid` and `fetch_err`.
  - If `jump_flag`=1 in OUT, with or without `inst_ready`: the redirect wins. pc=`jump_target`, drop `inst_valid`, go to AR.
- **Redirect in AR or R:** the address is already committed, so the outstanding read is never cancelled.
  - Set redirect-pending and store `jump_target`. A later `jump_flag` before completion overwrites it; the latest target wins.
  - The response is accepted and discarded as described under R. Nothing reaches decode.
- **Redirect in IDLE:** pc=`jump_target` directly; the first AR uses it.
- `jump_target` bit[1:0] is passed through unmodified; alignment is not checked here.
- One read is outstanding at most. `imem_arvalid` and `imem_rready` are never high together.

## Timing

- Zero-wait memory (arready and rvalid high the cycle the FSM reaches AR/R):
  - AR handshake at cycle N;
  - R handshake at N+1;
  - `inst_valid`=1 at N+2;
  - if `inst_ready`=1 at N+2, next `imem_arvalid` at N+3.
  - Throughput is 1 instruction per 3 cycles.
- After `rst_n` rises, at least 1 cycle of IDLE passes before `imem_arvalid`=1.
- Each cycle of low `imem_arready`, late `imem_rvalid` or low `inst_ready` adds exactly one cycle.
- A redirect in OUT at cycle K gives `inst_valid`=0 and `imem_arvalid`=1 with `imem_araddr`=`jump_target` at K+1.
- A redirect pending in R gives `imem_arvalid`=1 at target the cycle after the R handshake.
- `jump_flag` is sampled every cycle in every state. It is never lost, except to reset.

## Test plan

- **Reset and first fetch.**
  - Stimulus: hold `rst_n`=0 for 3 cycles, then release with arready=rvalid=1 and rdata=0x00000413.
  - Required response: all outputs at reset values during reset; arvalid with araddr=0x80000000 at release+1; inst_valid with inst_if=0x00000413 and pc_if=0x80000000 at release+3.
- **Sequential fetch under backpressure.**
  - Stimulus: zero-wait memory, then arready low 2 cycles and inst_ready low 3 cycles.
  - Required response: pc_if sequence 0x80000000, 0x80000004, 0x80000008; araddr and inst_if held stable while stalled; each stall adds exactly its cycle count.
- **Redirect in OUT.**
  - Stimulus: jump_flag=1 with jump_target=0x80000100 while inst_valid=1 and inst_ready=1.
  - Required response: next cycle inst_valid=0 and araddr=0x80000100; the next presented pc_if=0x80000100.
- **Redirect in flight.**
  - Stimulus: jump_flag at 0x80000200 during R with rvalid delayed 4 cycles, then a second jump at 0x80000300 before rvalid.
  - Required response: the response from the old address is discarded with inst_valid never asserted; the next araddr=0x80000300.
- **Error response.**
  - Stimulus: rresp=2'b10.
  - Required response: inst_valid=1, inst_if=0, fetch_err=1; on handshake fetch_err=0 and pc advances by 4.
- **Reset mid-operation.**
  - Stimulus: assert `rst_n`=0 in R with a redirect pending.
  - Required response: the next edge returns all outputs to reset values and clears pending; the fetch restarts at 0x80000000.
